nonce_dispatcher: RTL and testbench
===================================

// Module: nonce_dispatcher
// PURPOSE
//  Work scheduler between the UART receive path and a bank of NUM_CORES hash cores.
//  Latches a 640-bit block header from the serial core and carves the 32-bit nonce space into CHUNK-sized ranges.
//  Hands ranges to idle cores and collects found nonces by round-robin arbitration.
//  Presents found nonces one at a time to the UART transmit path over a valid/ready handshake.
// PARAMETERS
//  NUM_CORES  4        number of hash cores served (1..16)
//  CHUNK      2**20    nonces per dispatched range; power of two, <= 2**31
// PORTS
//  clock            in   1             system clock (50 MHz domain); single clock
//  reset            in   1             synchronous, active-high
//  work_valid       in   1             1-cycle pulse: new header on header_in
//  header_in        in   640           block header; header_in[31:0] = starting nonce
//  header_out       out  640           latched header, broadcast to all cores
//  core_start       out  NUM_CORES     one-hot 1-cycle pulse: core i begins range
//  core_nonce_base  out  32            range base, valid with core_start
//  core_abort       out  1             1-cycle pulse: all cores drop current range
//  core_done        in   NUM_CORES     pulse: core i finished its range (now idle)
//  core_found       in   NUM_CORES     pulse: core i found a nonce
//  core_found_nonce in   NUM_CORES*32  nonce of core i, slice [32i+31:32i], valid with core_found[i]
//  result_valid     out  1             found nonce available
//  result_nonce     out  32            found nonce, stable while result_valid
//  result_ready     in   1             transmit path accepts result
//  busy             out  1             dispatching or cores running
//  exhausted        out  1             nonce space for current header fully searched
//  find_overflow    out  1             sticky: a find was dropped
// BEHAVIOUR
//  Reset: all outputs 0; core_busy, found_pend, rr_ptr, nonce counter cleared; state IDLE.
//  States: IDLE -> (work_valid) DISPATCH <-> RUN -> (space_done & all idle & nothing pending) IDLE.
//  work_valid, any state (including mid-run):
//   - latch header, next_nonce <= {1'b0, header_in[31:0]} (33-bit)
//   - core_abort=1 next cycle; clear core_busy, found_pend, result_valid (only case valid drops without ready)
//   - clear exhausted and space_done; go DISPATCH
//   - work_valid wins over all same-cycle core_done/core_found, which are discarded.
//  DISPATCH: at most one start per cycle, to the lowest-index idle core.
//   - core_start[i]=1, core_nonce_base=next_nonce[31:0], core_busy[i]<=1, next_nonce+=CHUNK.
//   - If the add carries into bit 32: space_done<=1; no further starts.
//   - First start occurs the cycle after core_abort; goes to RUN when no core idle or space_done.
//  RUN: core_done[i] clears core_busy[i]; returns to DISPATCH next cycle if !space_done.
//  Ranges are not truncated: the final range ends at 0xFFFFFFFF when CHUNK divides the remaining space; otherwise the core clips at wrap.
//  Finds:
//   - core_found[i] sets found_pend[i] and captures nonce into per-core holding reg.
//   - core_found[i] while found_pend[i] already set: new nonce dropped, find_overflow<=1 (cleared only by reset).
//   - Output reg empty, or emptying this cycle (valid & ready): round-robin grant among found_pend, starting at rr_ptr.
//   - Grant loads result_nonce, clears that pend bit, rr_ptr <= winner+1 (mod NUM_CORES).
//   - Back-to-back throughput: one result per cycle.
//   - result_nonce/result_valid held until result_ready; finds never block dispatch.
//  exhausted<=1, busy<=0 when space_done, core_busy==0, found_pend==0 and !result_valid.
//  busy=1 in DISPATCH and RUN.
// STRUCTURE
//  miner_pkg: HEADER_W=640, NONCE_W=32, state encodings (IDLE, DISPATCH, RUN).
//  Sub-module rr_arbiter (NUM_CORES-wide request/grant, pointer update on grant).
//  Lowest-idle priority encoder, counters and FSM stay in this file.
// TESTING
//  1 NUM_CORES=4, CHUNK=16, work_valid header[31:0]=0 -> core_abort next cycle; core_start 0001,0010,0100,1000 on following 4 cycles with bases 0x0,0x10,0x20,0x30.
//  2 Then core_done[1] -> within 2 cycles core_start=0010, base 0x40.
//  3 Same cycle core_found[0]=0x5, core_found[2]=0x27, result_ready=0:
//    - result_valid=1, nonce 0x5 held 10 cycles
//    - ready 1 cycle -> next cycle nonce 0x27; then valid=0.
//  4 header[31:0]=0xFFFFFFE0, CHUNK=16:
//    - exactly two starts (0xFFFFFFE0, 0xFFFFFFF0), no further starts
//    - both done -> exhausted=1, busy=0.
//  5 work_valid mid-RUN with result_valid=1 -> core_abort pulse; result_valid=0 next cycle; redispatch from new base; mid-run reset -> all outputs 0.
//  6 core_found[3] twice before grant (ready=0) -> first nonce reported, second dropped, find_overflow=1 stays set.

Source files
------------

// File: rtl/nonce_dispatcher_pkg.sv
// Shared widths and FSM encoding for the nonce dispatcher slice.
package nonce_dispatcher_pkg;

    localparam int unsigned HEADER_W = 640;
    localparam int unsigned NONCE_W  = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        RUN      = 2'd2
    } disp_state_e;

    // Index width for an N-entry vector; never collapses to zero bits.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nonce_dispatcher_rr_arbiter.sv
// Round-robin arbiter: rotating search from rr_ptr, pointer moves past the winner on grant.
module nonce_dispatcher_rr_arbiter
    import nonce_dispatcher_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic [N-1:0]          req_i,
    input  logic                  en_i,
    output logic                  gnt_valid_c_o,
    output logic [idx_w(N)-1:0]   gnt_idx_c_o
);

    localparam int unsigned IDX_W = idx_w(N);
    localparam int unsigned CW    = IDX_W + 1;
    localparam logic [CW-1:0] N_C = CW'(N);

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]    cand;
    logic [CW-1:0]    ptr_inc;
    logic             hit;
    logic [IDX_W-1:0] win;

    // First requester found walking upward (with wrap) from the pointer
    always_comb begin
        hit  = 1'b0;
        win  = '0;
        cand = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = {1'b0, rr_ptr_q} + CW'(k);
            if (cand >= N_C) begin
                cand = cand - N_C;
            end
            if (!hit && req_i[cand[IDX_W-1:0]]) begin
                hit = 1'b1;
                win = cand[IDX_W-1:0];
            end
        end
    end

    // Pointer advances to winner+1 (mod N) only when a grant is taken
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        ptr_inc  = {1'b0, win} + CW'(1);
        if (ptr_inc >= N_C) begin
            ptr_inc = '0;
        end
        if (en_i && hit) begin
            rr_ptr_d = ptr_inc[IDX_W-1:0];
        end
    end

    assign gnt_valid_c_o = en_i && hit;
    assign gnt_idx_c_o   = win;

    // Pointer register
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/nonce_dispatcher.sv
// Work scheduler: carves the nonce space into CHUNK ranges for idle cores and
// funnels found nonces to the transmit path one at a time.
module nonce_dispatcher
    import nonce_dispatcher_pkg::*;
#(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned CHUNK     = 32'd1 << 20
) (
    input  logic                           clock_i,
    input  logic                           reset_i,
    input  logic                           work_valid_i,
    input  logic [HEADER_W-1:0]            header_in_i,
    output logic [HEADER_W-1:0]            header_out_o,
    output logic [NUM_CORES-1:0]           core_start_o,
    output logic [NONCE_W-1:0]             core_nonce_base_o,
    output logic                           core_abort_o,
    input  logic [NUM_CORES-1:0]           core_done_i,
    input  logic [NUM_CORES-1:0]           core_found_i,
    input  logic [NUM_CORES*NONCE_W-1:0]   core_found_nonce_i,
    output logic                           result_valid_o,
    output logic [NONCE_W-1:0]             result_nonce_o,
    input  logic                           result_ready_i,
    output logic                           busy_o,
    output logic                           exhausted_o,
    output logic                           find_overflow_o
);

    localparam int unsigned IDX_W = idx_w(NUM_CORES);
    localparam logic [NONCE_W:0] CHUNK_W = (NONCE_W + 1)'(CHUNK);

    disp_state_e              state_q, state_d;
    logic [HEADER_W-1:0]      header_q, header_d;
    logic [NONCE_W:0]         next_nonce_q, next_nonce_d;
    logic                     space_done_q, space_done_d;
    logic [NUM_CORES-1:0]     core_busy_q, core_busy_d;
    logic [NUM_CORES-1:0]     found_pend_q, found_pend_d;
    logic [NONCE_W-1:0]       hold_q [NUM_CORES];
    logic [NONCE_W-1:0]       hold_d [NUM_CORES];
    logic                     result_valid_q, result_valid_d;
    logic [NONCE_W-1:0]       result_nonce_q, result_nonce_d;
    logic [NUM_CORES-1:0]     core_start_q, core_start_d;
    logic [NONCE_W-1:0]       core_base_q, core_base_d;
    logic                     core_abort_q, core_abort_d;
    logic                     busy_q, busy_d;
    logic                     exhausted_q, exhausted_d;
    logic                     overflow_q, overflow_d;

    logic [NUM_CORES-1:0]     idle_oh;
    logic                     idle_any;
    logic [NONCE_W:0]         nonce_sum;
    logic                     arb_en_c;
    logic                     gnt_valid_c;
    logic [IDX_W-1:0]         gnt_idx_c;

    // A new header preempts everything, so no grant is taken on that cycle
    assign arb_en_c = !work_valid_i && (!result_valid_q || result_ready_i);

    nonce_dispatcher_rr_arbiter #(
        .N (NUM_CORES)
    ) u_arb (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .req_i         (found_pend_q),
        .en_i          (arb_en_c),
        .gnt_valid_c_o (gnt_valid_c),
        .gnt_idx_c_o   (gnt_idx_c)
    );

    // Lowest-index idle core, one-hot
    always_comb begin
        idle_oh  = '0;
        idle_any = 1'b0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (!core_busy_q[i] && !idle_any) begin
                idle_oh[i] = 1'b1;
                idle_any   = 1'b1;
            end
        end
    end

    assign nonce_sum = next_nonce_q + CHUNK_W;

    // Next-state: header load, find capture, result hand-off and dispatch FSM
    always_comb begin
        state_d        = state_q;
        header_d       = header_q;
        next_nonce_d   = next_nonce_q;
        space_done_d   = space_done_q;
        core_busy_d    = core_busy_q;
        found_pend_d   = found_pend_q;
        hold_d         = hold_q;
        result_valid_d = result_valid_q;
        result_nonce_d = result_nonce_q;
        core_start_d   = '0;
        core_base_d    = core_base_q;
        core_abort_d   = 1'b0;
        exhausted_d    = exhausted_q;
        overflow_d     = overflow_q;

        if (work_valid_i) begin
            header_d       = header_in_i;
            next_nonce_d   = {1'b0, header_in_i[NONCE_W-1:0]};
            core_abort_d   = 1'b1;
            core_busy_d    = '0;
            found_pend_d   = '0;
            result_valid_d = 1'b0;
            exhausted_d    = 1'b0;
            space_done_d   = 1'b0;
            state_d        = DISPATCH;
        end else begin
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                if (core_found_i[i]) begin
                    if (found_pend_q[i]) begin
                        overflow_d = 1'b1;
                    end else begin
                        found_pend_d[i] = 1'b1;
                        hold_d[i]       = core_found_nonce_i[NONCE_W*i +: NONCE_W];
                    end
                end
            end

            if (result_valid_q && result_ready_i) begin
                result_valid_d = 1'b0;
            end
            if (gnt_valid_c) begin
                result_valid_d          = 1'b1;
                result_nonce_d          = hold_q[gnt_idx_c];
                found_pend_d[gnt_idx_c] = 1'b0;
            end

            case (state_q)
                DISPATCH: begin
                    core_busy_d = core_busy_q & ~core_done_i;
                    if (!space_done_q && idle_any) begin
                        core_start_d = idle_oh;
                        core_base_d  = next_nonce_q[NONCE_W-1:0];
                        core_busy_d  = core_busy_d | idle_oh;
                        next_nonce_d = nonce_sum;
                        space_done_d = nonce_sum[NONCE_W];
                    end
                    if (space_done_d || (&core_busy_d)) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    core_busy_d = core_busy_q & ~core_done_i;
                    if (!space_done_q && !(&core_busy_d)) begin
                        state_d = DISPATCH;
                    end else if (space_done_q && (core_busy_q == '0) &&
                                 (found_pend_q == '0) && !result_valid_q) begin
                        state_d     = IDLE;
                        exhausted_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q        <= IDLE;
            header_q       <= '0;
            next_nonce_q   <= '0;
            space_done_q   <= 1'b0;
            core_busy_q    <= '0;
            found_pend_q   <= '0;
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                hold_q[i] <= '0;
            end
            result_valid_q <= 1'b0;
            result_nonce_q <= '0;
            core_start_q   <= '0;
            core_base_q    <= '0;
            core_abort_q   <= 1'b0;
            busy_q         <= 1'b0;
            exhausted_q    <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            header_q       <= header_d;
            next_nonce_q   <= next_nonce_d;
            space_done_q   <= space_done_d;
            core_busy_q    <= core_busy_d;
            found_pend_q   <= found_pend_d;
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                hold_q[i] <= hold_d[i];
            end
            result_valid_q <= result_valid_d;
            result_nonce_q <= result_nonce_d;
            core_start_q   <= core_start_d;
            core_base_q    <= core_base_d;
            core_abort_q   <= core_abort_d;
            busy_q         <= busy_d;
            exhausted_q    <= exhausted_d;
            overflow_q     <= overflow_d;
        end
    end

    assign header_out_o      = header_q;
    assign core_start_o      = core_start_q;
    assign core_nonce_base_o = core_base_q;
    assign core_abort_o      = core_abort_q;
    assign result_valid_o    = result_valid_q;
    assign result_nonce_o    = result_nonce_q;
    assign busy_o            = busy_q;
    assign exhausted_o       = exhausted_q;
    assign find_overflow_o   = overflow_q;

endmodule

// File: tb/tb_nonce_dispatcher.sv
// Bench for nonce_dispatcher: directed scenarios plus randomized rounds checked
// against a transaction-level model of ranges, finds and results.
module tb_nonce_dispatcher;

    localparam int unsigned NC    = 4;
    localparam int unsigned CHUNK = 16;
    localparam int unsigned HW    = 640;

    logic              clock = 1'b0;
    logic              reset;
    logic              work_valid;
    logic [HW-1:0]     header_in;
    logic [HW-1:0]     header_out;
    logic [NC-1:0]     core_start;
    logic [31:0]       core_nonce_base;
    logic              core_abort;
    logic [NC-1:0]     core_done;
    logic [NC-1:0]     core_found;
    logic [NC*32-1:0]  core_found_nonce;
    logic              result_valid;
    logic [31:0]       result_nonce;
    logic              result_ready;
    logic              busy;
    logic              exhausted;
    logic              find_overflow;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    nonce_dispatcher #(
        .NUM_CORES (NC),
        .CHUNK     (CHUNK)
    ) dut (
        .clock_i            (clock),
        .reset_i            (reset),
        .work_valid_i       (work_valid),
        .header_in_i        (header_in),
        .header_out_o       (header_out),
        .core_start_o       (core_start),
        .core_nonce_base_o  (core_nonce_base),
        .core_abort_o       (core_abort),
        .core_done_i        (core_done),
        .core_found_i       (core_found),
        .core_found_nonce_i (core_found_nonce),
        .result_valid_o     (result_valid),
        .result_nonce_o     (result_nonce),
        .result_ready_i     (result_ready),
        .busy_o             (busy),
        .exhausted_o        (exhausted),
        .find_overflow_o    (find_overflow)
    );

    task automatic check_eq(input string tag, input logic [HW-1:0] got, input logic [HW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got[63:0], exp[63:0]);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic make_header(input logic [31:0] base, output logic [HW-1:0] h);
        for (int w = 1; w < int'(HW / 32); w++) h[32*w +: 32] = $urandom;
        h[31:0] = base;
    endtask

    task automatic expect_start(input string tag, input logic [NC-1:0] oh, input logic [31:0] b);
        check_eq({tag, "_oh"}, HW'(core_start), HW'(oh));
        check_eq({tag, "_base"}, HW'(core_nonce_base), HW'(b));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_start"}, HW'(core_start), '0);
        check_eq({tag, "_base"}, HW'(core_nonce_base), '0);
        check_eq({tag, "_abort"}, HW'(core_abort), '0);
        check_eq({tag, "_rvalid"}, HW'(result_valid), '0);
        check_eq({tag, "_rnonce"}, HW'(result_nonce), '0);
        check_eq({tag, "_busy"}, HW'(busy), '0);
        check_eq({tag, "_exh"}, HW'(exhausted), '0);
        check_eq({tag, "_ovf"}, HW'(find_overflow), '0);
        check_eq({tag, "_hdr"}, header_out, '0);
    endtask

    logic [HW-1:0] hdr;
    bit            seen;

    bit            m_busy  [NC];
    int            m_tmr   [NC];
    logic [31:0]   m_base  [NC];
    bit            m_out   [NC];
    logic [31:0]   m_nonce [NC];

    initial begin
        reset            = 1'b1;
        work_valid       = 1'b0;
        header_in        = '0;
        core_done        = '0;
        core_found       = '0;
        core_found_nonce = '0;
        result_ready     = 1'b0;
        step();
        step();
        reset = 1'b0;
        check_all_zero("reset");

        // Test 1: header at nonce 0, four cores filled in index order
        make_header(32'h0, hdr);
        header_in  = hdr;
        work_valid = 1'b1;
        step();
        work_valid = 1'b0;
        check_eq("t1_abort", HW'(core_abort), HW'(1));
        check_eq("t1_nostart", HW'(core_start), '0);
        check_eq("t1_busy", HW'(busy), HW'(1));
        check_eq("t1_header", header_out, hdr);
        step(); expect_start("t1_s0", 4'b0001, 32'h00);
        check_eq("t1_abort_low", HW'(core_abort), '0);
        step(); expect_start("t1_s1", 4'b0010, 32'h10);
        step(); expect_start("t1_s2", 4'b0100, 32'h20);
        step(); expect_start("t1_s3", 4'b1000, 32'h30);
        step(); check_eq("t1_idle_start", HW'(core_start), '0);

        // Test 2: core 1 finishes, gets next range
        core_done = 4'b0010;
        step();
        core_done = '0;
        seen = 1'b0;
        for (int c = 0; c < 2 && !seen; c++) begin
            if (core_start != '0) seen = 1'b1;
            else step();
        end
        check_eq("t2_start_seen", HW'(seen), HW'(1));
        expect_start("t2", 4'b0010, 32'h40);

        // Test 3: two simultaneous finds, held until ready
        core_found       = 4'b0101;
        core_found_nonce = '0;
        core_found_nonce[31:0]  = 32'h5;
        core_found_nonce[95:64] = 32'h27;
        step();
        core_found = '0;
        step();
        for (int c = 0; c < 10; c++) begin
            check_eq("t3_hold_valid", HW'(result_valid), HW'(1));
            check_eq("t3_hold_nonce", HW'(result_nonce), HW'(32'h5));
            step();
        end
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        check_eq("t3_second_valid", HW'(result_valid), HW'(1));
        check_eq("t3_second_nonce", HW'(result_nonce), HW'(32'h27));
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        check_eq("t3_drained", HW'(result_valid), '0);

        // Test 5: new work mid-run while a result is pending
        core_found = 4'b0010;
        core_found_nonce[63:32] = 32'h41;
        step();
        core_found = '0;
        step();
        check_eq("t5_pre_valid", HW'(result_valid), HW'(1));
        make_header(32'h1000, hdr);
        header_in  = hdr;
        work_valid = 1'b1;
        step();
        work_valid = 1'b0;
        check_eq("t5_abort", HW'(core_abort), HW'(1));
        check_eq("t5_valid_drop", HW'(result_valid), '0);
        check_eq("t5_header", header_out, hdr);
        for (int c = 0; c < int'(NC); c++) begin
            step();
            expect_start("t5_s", NC'(1) << c, 32'h1000 + 32'(c * int'(CHUNK)));
        end

        // Test 6: second find from the same core before its grant is dropped
        core_found = 4'b0001;
        core_found_nonce[31:0] = 32'h11;
        step();
        core_found = '0;
        step();
        check_eq("t6_first_nonce", HW'(result_nonce), HW'(32'h11));
        core_found = 4'b1000;
        core_found_nonce[127:96] = 32'hAA;
        step();
        core_found_nonce[127:96] = 32'hBB;
        step();
        core_found = '0;
        check_eq("t6_overflow", HW'(find_overflow), HW'(1));
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        check_eq("t6_kept_valid", HW'(result_valid), HW'(1));
        check_eq("t6_kept_nonce", HW'(result_nonce), HW'(32'hAA));
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        check_eq("t6_dropped", HW'(result_valid), '0);
        step();
        check_eq("t6_overflow_sticky", HW'(find_overflow), HW'(1));

        // Mid-run reset
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_all_zero("midreset");

        // Test 4: top of nonce space, exactly two ranges
        make_header(32'hFFFF_FFE0, hdr);
        header_in  = hdr;
        work_valid = 1'b1;
        step();
        work_valid = 1'b0;
        check_eq("t4_abort", HW'(core_abort), HW'(1));
        step(); expect_start("t4_s0", 4'b0001, 32'hFFFF_FFE0);
        step(); expect_start("t4_s1", 4'b0010, 32'hFFFF_FFF0);
        for (int c = 0; c < 4; c++) begin
            step();
            check_eq("t4_no_more", HW'(core_start), '0);
        end
        check_eq("t4_busy_run", HW'(busy), HW'(1));
        check_eq("t4_not_exh", HW'(exhausted), '0);
        core_done = 4'b0011;
        step();
        core_done = '0;
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            if (exhausted) seen = 1'b1;
            else step();
        end
        check_eq("t4_exhausted", HW'(exhausted), HW'(1));
        check_eq("t4_busy_low", HW'(busy), '0);

        // Randomized rounds near the top of the nonce space
        for (int r = 0; r < 6; r++) begin
            logic [31:0]      base;
            longint unsigned  exp_starts;
            int               starts;
            int               finds;
            int               results;
            bit               done_flag;
            int               idx;

            base       = 32'hFFFF_FFFF - 32'($urandom_range(0, 399));
            exp_starts = ((64'h1_0000_0000 - 64'(base)) + 64'(CHUNK - 1)) / 64'(CHUNK);
            starts     = 0;
            finds      = 0;
            results    = 0;
            done_flag  = 1'b0;
            for (int i = 0; i < int'(NC); i++) begin
                m_busy[i] = 1'b0;
                m_out[i]  = 1'b0;
                m_tmr[i]  = 0;
            end
            make_header(base, hdr);
            header_in  = hdr;
            work_valid = 1'b1;
            step();
            work_valid = 1'b0;
            check_eq("rand_abort", HW'(core_abort), HW'(1));
            check_eq("rand_header", header_out, hdr);

            for (int cyc = 0; cyc < 2000 && !done_flag; cyc++) begin
                core_done  = '0;
                core_found = '0;
                for (int i = 0; i < int'(NC); i++) begin
                    if (m_busy[i]) begin
                        if (!m_out[i] && $urandom_range(0, 5) == 0) begin
                            m_nonce[i] = m_base[i] + 32'($urandom_range(0, CHUNK - 1));
                            core_found[i] = 1'b1;
                            core_found_nonce[32*i +: 32] = m_nonce[i];
                            m_out[i] = 1'b1;
                            finds++;
                        end
                        if (m_tmr[i] <= 1) begin
                            core_done[i] = 1'b1;
                            m_busy[i]    = 1'b0;
                        end else begin
                            m_tmr[i]--;
                        end
                    end
                end
                result_ready = ($urandom_range(0, 2) != 0);
                if (result_valid && result_ready) begin
                    bit hit;
                    hit = 1'b0;
                    for (int i = 0; i < int'(NC); i++) begin
                        if (!hit && m_out[i] && m_nonce[i] == result_nonce) begin
                            hit      = 1'b1;
                            m_out[i] = 1'b0;
                        end
                    end
                    check_eq("rand_result_known", HW'(hit), HW'(1));
                    results++;
                end
                step();
                if (core_start != '0) begin
                    idx = 0;
                    for (int i = int'(NC) - 1; i >= 0; i--) if (core_start[i]) idx = i;
                    check_eq("rand_start_onehot", HW'($countones(core_start)), HW'(1));
                    check_eq("rand_start_idle", HW'(m_busy[idx]), '0);
                    check_eq("rand_start_count", HW'(longint'(starts) < longint'(exp_starts)), HW'(1));
                    check_eq("rand_start_base", HW'(core_nonce_base),
                             HW'(base + 32'(starts * int'(CHUNK))));
                    m_busy[idx] = 1'b1;
                    m_tmr[idx]  = int'($urandom_range(1, 6));
                    m_base[idx] = base + 32'(starts * int'(CHUNK));
                    starts++;
                end
                if (exhausted) done_flag = 1'b1;
            end
            core_done    = '0;
            core_found   = '0;
            result_ready = 1'b0;
            check_eq("rand_finished", HW'(done_flag), HW'(1));
            check_eq("rand_starts", HW'(starts), HW'(exp_starts));
            check_eq("rand_results", HW'(results), HW'(finds));
            check_eq("rand_busy_low", HW'(busy), '0);
            check_eq("rand_overflow", HW'(find_overflow), '0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
